step_pulse_gen: RTL and testbench

STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

---
 rtl/step_pulse_gen.sv | 144 ++++++++++++++
 tb/tb_step_pulse_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_gen.sv
// Step/direction pulse generator for a stepper motor driver.
// Emits a programmed number of fixed-period step pulses after a direction setup delay.
module step_pulse_gen #(
    parameter int unsigned PULSE_HIGH = 50,
    parameter int unsigned PERIOD     = 1000,
    parameter int unsigned DIR_SETUP  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] steps,
    input  logic        dir,
    input  logic        start,
    input  logic        abort,
    output logic        step_out,
    output logic        dir_out,
    output logic        busy,
    output logic        done,
    output logic [31:0] steps_left,
    output logic [31:0] position
);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_t;

    localparam logic [31:0] SETUP_LAST = 32'(DIR_SETUP - 1);
    localparam logic [31:0] HIGH_LAST  = 32'(PULSE_HIGH - 1);
    localparam logic [31:0] LOW_LAST   = 32'(PERIOD - PULSE_HIGH - 1);

    state_t      state, state_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic        step_nxt, dir_nxt, busy_nxt, done_nxt;
    logic [31:0] left_nxt, pos_nxt;
    logic        abort_hold, abort_hold_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            step_out   <= 1'b0;
            dir_out    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            steps_left <= '0;
            position   <= '0;
            abort_hold <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            step_out   <= step_nxt;
            dir_out    <= dir_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            steps_left <= left_nxt;
            position   <= pos_nxt;
            abort_hold <= abort_hold_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt + 32'd1;
        step_nxt       = step_out;
        dir_nxt        = dir_out;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        left_nxt       = steps_left;
        pos_nxt        = position;
        abort_hold_nxt = abort_hold;

        unique case (state)
            IDLE: begin
                cnt_nxt        = '0;
                abort_hold_nxt = 1'b0;
                if (start) begin
                    if (steps != '0) begin
                        left_nxt  = steps;
                        dir_nxt   = dir;
                        busy_nxt  = 1'b1;
                        state_nxt = SETUP;
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            SETUP: begin
                if (abort) begin
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else if (cnt == SETUP_LAST) begin
                    cnt_nxt   = '0;
                    step_nxt  = 1'b1;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                // An abort seen at any point in the pulse is remembered so the pulse runs to full width.
                if (abort)
                    abort_hold_nxt = 1'b1;
                if (cnt == HIGH_LAST) begin
                    cnt_nxt  = '0;
                    step_nxt = 1'b0;
                    left_nxt = steps_left - 32'd1;
                    pos_nxt  = dir_out ? position - 32'd1 : position + 32'd1;
                    if (abort || abort_hold) begin
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = LOW;
                    end
                end
            end
            LOW: begin
                if (abort) begin
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else if (cnt == LOW_LAST) begin
                    cnt_nxt = '0;
                    if (steps_left != '0) begin
                        step_nxt  = 1'b1;
                        state_nxt = HIGH;
                    end else begin
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: per-cycle expected step_out/busy/done profiles are
// queued when a move is started and popped on every falling edge.
module tb_step_pulse_gen;

    localparam int PH  = 2;
    localparam int PER = 5;
    localparam int DS  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] steps;
    logic        dir, start, abort;
    logic        step_out, dir_out, busy, done;
    logic [31:0] steps_left, position;

    typedef struct {
        logic s;
        logic b;
        logic d;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_pos  = '0;

    step_pulse_gen #(.PULSE_HIGH(PH), .PERIOD(PER), .DIR_SETUP(DS)) dut (
        .clk(clk), .reset(reset), .steps(steps), .dir(dir), .start(start), .abort(abort),
        .step_out(step_out), .dir_out(dir_out), .busy(busy), .done(done),
        .steps_left(steps_left), .position(position)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // k counts rising edges after the one that samples start (k=0).
    task automatic push_profile(input int end_k, input int ncyc);
        exp_t e;
        for (int k = 0; k < ncyc; k++) begin
            e.s = (k >= DS) && (k < end_k) && (((k - DS) % PER) < PH);
            e.b = (k < end_k);
            e.d = (k == end_k);
            q.push_back(e);
        end
    endtask

    task automatic run_cycles(input string tag, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL %s_queue observed=empty expected=entry", tag);
            end else begin
                e = q.pop_front();
                check({tag, "_step"}, 32'(step_out), 32'(e.s));
                check({tag, "_busy"}, 32'(busy), 32'(e.b));
                check({tag, "_done"}, 32'(done), 32'(e.d));
            end
        end
    endtask

    task automatic drive_start(input logic [31:0] n, input logic d);
        steps = n;
        dir   = d;
        start = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        steps = '0;
        dir   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("rst_step", 32'(step_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dir", 32'(dir_out), 32'd0);
        check("rst_left", steps_left, 32'd0);
        check("rst_pos", position, 32'd0);
        reset = 1'b1;

        // 3 positive steps; a second start while busy must be ignored.
        drive_start(32'd3, 1'b0);
        push_profile(DS + 3 * PER, DS + 3 * PER + 2);
        run_cycles("m3", 1);
        start = 1'b0;
        run_cycles("m3", 5);
        drive_start(32'd7, 1'b1);
        run_cycles("m3", 1);
        start = 1'b0;
        run_cycles("m3", DS + 3 * PER + 2 - 7);
        exp_pos = exp_pos + 32'd3;
        check("m3_pos", position, exp_pos);
        check("m3_left", steps_left, 32'd0);
        check("m3_dir", 32'(dir_out), 32'd0);

        // 5 negative steps from +3, wrapping through zero.
        drive_start(32'd5, 1'b1);
        push_profile(DS + 5 * PER, DS + 5 * PER + 2);
        run_cycles("m5", 1);
        start = 1'b0;
        check("m5_dir_early", 32'(dir_out), 32'd1);
        run_cycles("m5", DS + 5 * PER + 1);
        exp_pos = exp_pos - 32'd5;
        check("m5_pos", position, exp_pos);
        check("m5_pos_abs", position, 32'hFFFF_FFFE);

        // Zero-step move; start held into DONE must not retrigger.
        drive_start(32'd0, 1'b0);
        push_profile(0, 3);
        run_cycles("z0", 2);
        start = 1'b0;
        run_cycles("z0", 1);
        check("z0_pos", position, exp_pos);
        check("z0_dir", 32'(dir_out), 32'd1);

        // start and abort together in IDLE: the move starts.
        drive_start(32'd1, 1'b0);
        abort = 1'b1;
        push_profile(DS + PER, DS + PER + 2);
        run_cycles("sa", 1);
        start = 1'b0;
        abort = 1'b0;
        run_cycles("sa", DS + PER + 1);
        exp_pos = exp_pos + 32'd1;
        check("sa_pos", position, exp_pos);

        // Abort during SETUP ends the move on the next edge with no step.
        drive_start(32'd4, 1'b1);
        push_profile(1, 3);
        run_cycles("as", 1);
        start = 1'b0;
        abort = 1'b1;
        run_cycles("as", 1);
        abort = 1'b0;
        run_cycles("as", 1);
        check("as_pos", position, exp_pos);
        check("as_left", steps_left, 32'd4);

        // Abort during the 2nd HIGH pulse: pulse completes, then DONE.
        drive_start(32'd10, 1'b0);
        push_profile(DS + PER + PH, DS + PER + PH + 2);
        run_cycles("ah", 1);
        start = 1'b0;
        run_cycles("ah", DS + PER);
        abort = 1'b1;
        run_cycles("ah", 1);
        abort = 1'b0;
        run_cycles("ah", 2);
        exp_pos = exp_pos + 32'd2;
        check("ah_pos", position, exp_pos);
        check("ah_left", steps_left, 32'd8);
        check("ah_dir", 32'(dir_out), 32'd0);

        // Asynchronous reset during HIGH.
        drive_start(32'd4, 1'b0);
        push_profile(DS + 4 * PER, DS + 1);
        run_cycles("rr", 1);
        start = 1'b0;
        run_cycles("rr", DS);
        #2 reset = 1'b0;
        #1;
        check("rr_step", 32'(step_out), 32'd0);
        check("rr_busy", 32'(busy), 32'd0);
        check("rr_pos", position, 32'd0);
        check("rr_left", steps_left, 32'd0);
        @(negedge clk);
        check("rr_done", 32'(done), 32'd0);
        check("rr_dir", 32'(dir_out), 32'd0);
        reset = 1'b1;
        exp_pos = '0;

        // First edge after reset release accepts start.
        drive_start(32'd1, 1'b1);
        push_profile(DS + PER, DS + PER + 2);
        run_cycles("pr", 1);
        start = 1'b0;
        run_cycles("pr", DS + PER + 1);
        exp_pos = exp_pos - 32'd1;
        check("pr_pos", position, exp_pos);
        check("pr_dir", 32'(dir_out), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
